// File: rtl/dmc_pkg.sv
// Shared constants, command encodings and address range check for dual_mem_controller.
`ifndef DMC_PKG_SV
`define DMC_PKG_SV

// True when a requester address falls outside the populated memory words.
`define DMC_ADDR_OOR(addr, depth) (32'(addr) >= 32'(depth))

package dmc_pkg;

  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDepth     = 16;
  localparam int unsigned Latency      = 2;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_e;

endpackage

`endif

// File: rtl/dual_mem_controller_if.sv
// Requester-side request/response bundle for one dual_mem_controller port.
interface dual_mem_controller_if #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmc_port_stage.sv
// One memory port: command register, pin drive, bus tri-state, read capture and response register.
module dmc_port_stage
  import dmc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic                  mem_oe_o,
  inout  wire  [DATA_WIDTH-1:0] mem_data_io
);

  cmd_e                  cmd_q, cmd_d;
  logic                  oor_q, oor_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  always_comb begin
    cmd_d   = CMD_IDLE;
    oor_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept_i) begin
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
      // Out-of-range requests never reach the memory pins, only the response stage.
      if (`DMC_ADDR_OOR(req_addr_i, DEPTH)) begin
        oor_d = 1'b1;
      end else begin
        cmd_d = req_we_i ? CMD_WR : CMD_RD;
      end
    end
    resp_valid_d = (cmd_q != CMD_IDLE) || oor_q;
    resp_err_d   = oor_q;
    resp_rdata_d = (cmd_q == CMD_RD) ? mem_data_io : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= CMD_IDLE;
      oor_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      cmd_q        <= cmd_d;
      oor_q        <= oor_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_cs_o     = (cmd_q != CMD_IDLE);
  assign mem_we_o     = (cmd_q == CMD_WR);
  assign mem_oe_o     = (cmd_q == CMD_RD);
  assign mem_data_io  = (cmd_q == CMD_WR) ? wdata_q : 'z;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: rtl/dual_mem_controller.sv
// Two-requester front-end for the two-port memory with round-robin write-write arbitration.
// Optional DMC_CONFLICT_CNT_EN adds a saturating conflict_cnt output.
module dual_mem_controller
  import dmc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  dual_mem_controller_if.slave  req0,
  dual_mem_controller_if.slave  req1,
  output logic [ADDR_WIDTH-1:0] mem_addr_0,
  output logic                  mem_cs_0,
  output logic                  mem_we_0,
  output logic                  mem_oe_0,
  inout  wire  [DATA_WIDTH-1:0] mem_data_0,
  output logic [ADDR_WIDTH-1:0] mem_addr_1,
  output logic                  mem_cs_1,
  output logic                  mem_we_1,
  output logic                  mem_oe_1,
  inout  wire  [DATA_WIDTH-1:0] mem_data_1
`ifdef DMC_CONFLICT_CNT_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  logic wr_0, wr_1, conflict;
  logic accept_0, accept_1;
  logic ptr_q, ptr_d;

  // Only in-range writes can collide inside the memory.
  assign wr_0     = req0.req_valid && req0.req_we && !`DMC_ADDR_OOR(req0.req_addr, DEPTH);
  assign wr_1     = req1.req_valid && req1.req_we && !`DMC_ADDR_OOR(req1.req_addr, DEPTH);
  assign conflict = wr_0 && wr_1;

  assign req0.req_ready = !conflict || !ptr_q;
  assign req1.req_ready = !conflict || ptr_q;
  assign accept_0       = req0.req_valid && req0.req_ready;
  assign accept_1       = req1.req_valid && req1.req_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (conflict) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`ifdef DMC_CONFLICT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

  dmc_port_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_stage_0 (
    .clk          (clk),
    .rst          (rst),
    .accept_i     (accept_0),
    .req_we_i     (req0.req_we),
    .req_addr_i   (req0.req_addr),
    .req_wdata_i  (req0.req_wdata),
    .resp_valid_o (req0.resp_valid),
    .resp_rdata_o (req0.resp_rdata),
    .resp_err_o   (req0.resp_err),
    .mem_addr_o   (mem_addr_0),
    .mem_cs_o     (mem_cs_0),
    .mem_we_o     (mem_we_0),
    .mem_oe_o     (mem_oe_0),
    .mem_data_io  (mem_data_0)
  );

  dmc_port_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_stage_1 (
    .clk          (clk),
    .rst          (rst),
    .accept_i     (accept_1),
    .req_we_i     (req1.req_we),
    .req_addr_i   (req1.req_addr),
    .req_wdata_i  (req1.req_wdata),
    .resp_valid_o (req1.resp_valid),
    .resp_rdata_o (req1.resp_rdata),
    .resp_err_o   (req1.resp_err),
    .mem_addr_o   (mem_addr_1),
    .mem_cs_o     (mem_cs_1),
    .mem_we_o     (mem_we_1),
    .mem_oe_o     (mem_oe_1),
    .mem_data_io  (mem_data_1)
  );

endmodule

// File: tb/tb_dual_mem_controller.sv
// Directed-vector bench for dual_mem_controller with a behavioural two-port memory.
module tb_dual_mem_controller;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr_0, mem_addr_1;
  logic        mem_cs_0, mem_we_0, mem_oe_0;
  logic        mem_cs_1, mem_we_1, mem_oe_1;
  wire  [3:0]  mem_data_0, mem_data_1;
`ifdef DMC_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dual_mem_controller_if #(.DATA_WIDTH(4), .ADDR_WIDTH(16)) req0_if ();
  dual_mem_controller_if #(.DATA_WIDTH(4), .ADDR_WIDTH(16)) req1_if ();

  dual_mem_controller #(
    .DATA_WIDTH (4),
    .ADDR_WIDTH (16),
    .DEPTH      (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0_if),
    .req1       (req1_if),
    .mem_addr_0 (mem_addr_0),
    .mem_cs_0   (mem_cs_0),
    .mem_we_0   (mem_we_0),
    .mem_oe_0   (mem_oe_0),
    .mem_data_0 (mem_data_0),
    .mem_addr_1 (mem_addr_1),
    .mem_cs_1   (mem_cs_1),
    .mem_we_1   (mem_we_1),
    .mem_oe_1   (mem_oe_1),
    .mem_data_1 (mem_data_1)
`ifdef DMC_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reads latch on the falling edge, writes commit on the rising edge,
  // port 0 wins a same-address write collision.
  logic [3:0] mem_arr [16];
  logic [3:0] rd_0, rd_1;
  logic       mdrv_0, mdrv_1;

  assign mdrv_0     = mem_cs_0 && mem_oe_0 && !mem_we_0;
  assign mdrv_1     = mem_cs_1 && mem_oe_1 && !mem_we_1;
  assign mem_data_0 = mdrv_0 ? rd_0 : 4'bz;
  assign mem_data_1 = mdrv_1 ? rd_1 : 4'bz;

  always @(negedge clk) begin
    if (mdrv_0) rd_0 <= mem_arr[mem_addr_0[3:0]];
    if (mdrv_1) rd_1 <= mem_arr[mem_addr_1[3:0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem_arr[i] <= 4'h0;
    end else begin
      if (mem_cs_0 && mem_we_0) mem_arr[mem_addr_0[3:0]] <= mem_data_0;
      if (mem_cs_1 && mem_we_1 && !(mem_cs_0 && mem_we_0 && mem_addr_0 == mem_addr_1))
        mem_arr[mem_addr_1[3:0]] <= mem_data_1;
    end
  end

  typedef struct {
    logic        v0, we0;
    logic [15:0] a0;
    logic [3:0]  d0;
    logic        v1, we1;
    logic [15:0] a1;
    logic [3:0]  d1;
    logic        rdy0, rdy1, rv0, rv1;
    logic [3:0]  rd0, rd1;
    logic        err0, err1, cs0, cs1;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [15:0] a0, input logic [3:0] d0,
                       input logic v1, input logic we1, input logic [15:0] a1,
                       input logic [3:0] d1);
    req0_if.req_valid = v0;
    req0_if.req_we    = we0;
    req0_if.req_addr  = a0;
    req0_if.req_wdata = d0;
    req1_if.req_valid = v1;
    req1_if.req_we    = we1;
    req1_if.req_addr  = a1;
    req1_if.req_wdata = d1;
  endtask

  initial begin
    // v0,we0,a0,d0, v1,we1,a1,d1, rdy0,rdy1, rv0,rv1, rd0,rd1, err0,err1, cs0,cs1
    vecs[0]  = '{1,1,3,4'hA, 0,0,0,0,   1,1, 0,0, 0,0,       0,0, 0,0};
    vecs[1]  = '{0,0,0,0,    1,0,3,0,   1,1, 0,0, 0,0,       0,0, 1,0};
    vecs[2]  = '{0,0,0,0,    0,0,0,0,   1,1, 1,0, 0,0,       0,0, 0,1};
    vecs[3]  = '{1,1,5,4'h1, 1,1,6,4'h2, 1,0, 0,1, 0,4'hA,   0,0, 0,0};
    vecs[4]  = '{0,0,0,0,    1,1,6,4'h2, 1,1, 0,0, 0,0,      0,0, 1,0};
    vecs[5]  = '{1,1,7,4'h3, 1,1,8,4'h4, 0,1, 1,0, 0,0,      0,0, 0,1};
    vecs[6]  = '{1,1,7,4'h3, 0,0,0,0,   1,1, 0,1, 0,0,       0,0, 0,1};
    vecs[7]  = '{1,1,2,4'h4, 0,0,0,0,   1,1, 0,1, 0,0,       0,0, 1,0};
    vecs[8]  = '{1,1,2,4'h7, 1,0,2,0,   1,1, 1,0, 0,0,       0,0, 1,0};
    vecs[9]  = '{1,0,5,0,    1,0,6,0,   1,1, 1,0, 0,0,       0,0, 1,1};
    vecs[10] = '{1,0,2,0,    1,0,16,0,  1,1, 1,1, 0,4'h4,    0,0, 1,1};
    vecs[11] = '{0,0,0,0,    0,0,0,0,   1,1, 1,1, 4'h1,4'h2, 0,0, 1,0};
    vecs[12] = '{1,1,20,4'hF, 1,1,9,4'h5, 1,1, 1,1, 4'h7,0,  0,1, 0,0};
    vecs[13] = '{0,0,0,0,    0,0,0,0,   1,1, 0,0, 0,0,       0,0, 0,1};
    vecs[14] = '{0,0,0,0,    0,0,0,0,   1,1, 1,1, 0,0,       1,0, 0,0};
    vecs[15] = '{1,0,8,0,    1,0,7,0,   1,1, 0,0, 0,0,       0,0, 0,0};
    vecs[16] = '{0,0,0,0,    0,0,0,0,   1,1, 0,0, 0,0,       0,0, 1,1};
    vecs[17] = '{0,0,0,0,    0,0,0,0,   1,1, 1,1, 4'h4,4'h3, 0,0, 0,0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset cs0", 16'(mem_cs_0), 16'd0);
    chk("reset we0", 16'(mem_we_0), 16'd0);
    chk("reset oe0", 16'(mem_oe_0), 16'd0);
    chk("reset cs1", 16'(mem_cs_1), 16'd0);
    chk("reset we1", 16'(mem_we_1), 16'd0);
    chk("reset oe1", 16'(mem_oe_1), 16'd0);
    chk("reset addr0", mem_addr_0, 16'd0);
    chk("reset addr1", mem_addr_1, 16'd0);
    chk("reset rv0", 16'(req0_if.resp_valid), 16'd0);
    chk("reset rv1", 16'(req1_if.resp_valid), 16'd0);
    chk("reset rd0", 16'(req0_if.resp_rdata), 16'd0);
    chk("reset err1", 16'(req1_if.resp_err), 16'd0);
`ifdef DMC_CONFLICT_CNT_EN
    chk("reset conflict_cnt", conflict_cnt, 16'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("v%0d rdy0", i), 16'(req0_if.req_ready), 16'(vecs[i].rdy0));
      chk($sformatf("v%0d rdy1", i), 16'(req1_if.req_ready), 16'(vecs[i].rdy1));
      chk($sformatf("v%0d rv0", i), 16'(req0_if.resp_valid), 16'(vecs[i].rv0));
      chk($sformatf("v%0d rv1", i), 16'(req1_if.resp_valid), 16'(vecs[i].rv1));
      chk($sformatf("v%0d rdata0", i), 16'(req0_if.resp_rdata), 16'(vecs[i].rd0));
      chk($sformatf("v%0d rdata1", i), 16'(req1_if.resp_rdata), 16'(vecs[i].rd1));
      chk($sformatf("v%0d err0", i), 16'(req0_if.resp_err), 16'(vecs[i].err0));
      chk($sformatf("v%0d err1", i), 16'(req1_if.resp_err), 16'(vecs[i].err1));
      chk($sformatf("v%0d cs0", i), 16'(mem_cs_0), 16'(vecs[i].cs0));
      chk($sformatf("v%0d cs1", i), 16'(mem_cs_1), 16'(vecs[i].cs1));
      step();
    end

    // Reset arriving the cycle after a read is accepted flushes it.
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("flush read in flight cs0", 16'(mem_cs_0), 16'd1);
    chk("flush read in flight oe0", 16'(mem_oe_0), 16'd1);
    step();
    chk("flush cs0", 16'(mem_cs_0), 16'd0);
    chk("flush oe0", 16'(mem_oe_0), 16'd0);
    chk("flush we0", 16'(mem_we_0), 16'd0);
    chk("flush addr0", mem_addr_0, 16'd0);
    chk("flush rv0", 16'(req0_if.resp_valid), 16'd0);
    rst = 1'b0;
    step();
    chk("flush rv0 later", 16'(req0_if.resp_valid), 16'd0);
    chk("flush cs0 later", 16'(mem_cs_0), 16'd0);

`ifdef DMC_CONFLICT_CNT_EN
    drive(1, 1, 1, 4'h1, 1, 1, 2, 4'h2);
    repeat (3) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("conflict_cnt after 3", conflict_cnt, 16'd3);
    rst = 1'b1;
    step();
    chk("conflict_cnt after rst", conflict_cnt, 16'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
